// File: rtl/soc_mem_region_bridge_if.sv
// Core-side request/response and slave-side bus of the memory region bridge.
// The bridge uses the slave modport; the core/slave environment uses master.
interface soc_mem_region_bridge_if #(
   parameter int XLEN        = 64,
   parameter int NUM_REGIONS = 4
);
   logic                          req_valid;
   logic                          req_we;
   logic [XLEN-1:0]               req_addr;
   logic [XLEN-1:0]               req_wdata;
   logic [1:0]                    req_size;
   logic                          req_ready;
   logic                          decode_err;
   logic                          rsp_valid;
   logic                          rsp_err;
   logic [XLEN-1:0]               rsp_rdata;
   logic [NUM_REGIONS-1:0]        slv_sel;
   logic                          slv_we;
   logic [XLEN-1:0]               slv_addr;
   logic [XLEN-1:0]               slv_wdata;
   logic [XLEN/8-1:0]             slv_be;
   logic [NUM_REGIONS-1:0]        slv_ack;
   logic [NUM_REGIONS*XLEN-1:0]   slv_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_size,
      output slv_ack, slv_rdata,
      input  req_ready, decode_err, rsp_valid, rsp_err, rsp_rdata,
      input  slv_sel, slv_we, slv_addr, slv_wdata, slv_be
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_size,
      input  slv_ack, slv_rdata,
      output req_ready, decode_err, rsp_valid, rsp_err, rsp_rdata,
      output slv_sel, slv_we, slv_addr, slv_wdata, slv_be
   );
endinterface

// File: rtl/soc_mem_region_bridge.sv
// Data-side bridge: decodes a core load/store against address windows and
// holds a registered request on one slave until it acks or times out.
module soc_mem_region_bridge #(
   parameter int                          XLEN         = 64,
   parameter int                          NUM_REGIONS  = 4,
   parameter logic [NUM_REGIONS*XLEN-1:0] REGION_BASE  = {64'h0000_0000_1000_0000, 64'h0000_0000_0000_2000,
                                                          64'h0000_0000_0000_1000, 64'h0000_0000_0000_0000},
   parameter logic [NUM_REGIONS*XLEN-1:0] REGION_LIMIT = {64'h0000_0000_1000_FFFF, 64'h0000_0000_0000_2FFF,
                                                          64'h0000_0000_0000_1FFF, 64'h0000_0000_0000_0FFF},
   parameter logic [NUM_REGIONS-1:0]      REGION_RO    = NUM_REGIONS'(1),
   parameter int                          TIMEOUT      = 15
) (
   input logic                  i_clk,
   input logic                  i_rst,
   input logic                  i_clk_en,
   soc_mem_region_bridge_if.slave bus
);

   localparam int LANES = XLEN / 8;
   localparam int LW    = $clog2(LANES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [NUM_REGIONS-1:0]  r_sel,       w_sel_next;
   logic                    r_we,        w_we_next;
   logic [XLEN-1:0]         r_addr,      w_addr_next;
   logic [XLEN-1:0]         r_wdata,     w_wdata_next;
   logic [LANES-1:0]        r_be,        w_be_next;
   logic [7:0]              r_cnt,       w_cnt_next;
   logic                    r_rsp_valid, w_rsp_valid_next;
   logic                    r_rsp_err,   w_rsp_err_next;
   logic [XLEN-1:0]         r_rsp_rdata, w_rsp_rdata_next;

   logic [NUM_REGIONS-1:0]  w_hit;
   logic [NUM_REGIONS-1:0]  w_sel_onehot;
   logic [XLEN-1:0]         w_base_sel;
   logic                    w_ro_hit;
   logic                    w_misalign;
   logic                    w_req_bad;
   logic [LANES-1:0]        w_be_mask;
   logic [LANES-1:0]        w_be;
   logic [XLEN-1:0]         w_wdata_rep;
   logic [XLEN-1:0]         w_slv_rdata_sel;
   logic                    w_ack;

   // ---------------- address decode ----------------
   generate
      for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_hit
         assign w_hit[gi] = (bus.req_addr >= REGION_BASE[gi*XLEN +: XLEN]) &&
                            (bus.req_addr <= REGION_LIMIT[gi*XLEN +: XLEN]);
      end
   endgenerate

   // Isolate the lowest set hit bit so overlapping windows resolve to the lowest index.
   assign w_sel_onehot = w_hit & (~w_hit + NUM_REGIONS'(1));
   assign w_ro_hit     = |(w_sel_onehot & REGION_RO);

   always_comb begin
      w_base_sel = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (w_sel_onehot[i]) begin
            w_base_sel = w_base_sel | REGION_BASE[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      w_misalign = 1'b0;
      case (bus.req_size)
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = bus.req_addr[0];
         2'b10:   w_misalign = |bus.req_addr[1:0];
         default: w_misalign = (XLEN != 64) || (|bus.req_addr[2:0]);
      endcase
   end

   assign w_req_bad      = ~(|w_hit) | w_misalign | (bus.req_we & w_ro_hit);
   assign bus.decode_err = bus.req_valid & w_req_bad;

   // ---------------- lane steering ----------------
   always_comb begin
      w_be_mask   = '1;
      w_wdata_rep = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            w_be_mask   = LANES'(1);
            w_wdata_rep = {LANES{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            w_be_mask   = LANES'(3);
            w_wdata_rep = {(LANES/2){bus.req_wdata[15:0]}};
         end
         2'b10: begin
            w_be_mask   = LANES'(15);
            w_wdata_rep = {(XLEN/32){bus.req_wdata[31:0]}};
         end
         default: begin
            w_be_mask   = '1;
            w_wdata_rep = bus.req_wdata;
         end
      endcase
   end

   assign w_be = w_be_mask << bus.req_addr[LW-1:0];

   // ---------------- slave return path ----------------
   always_comb begin
      w_slv_rdata_sel = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (r_sel[i]) begin
            w_slv_rdata_sel = w_slv_rdata_sel | bus.slv_rdata[i*XLEN +: XLEN];
         end
      end
   end

   // Acks from slaves that are not currently selected never count.
   assign w_ack = |(bus.slv_ack & r_sel);

   // ---------------- FSM next state ----------------
   always_comb begin
      w_state_next     = r_state;
      w_sel_next       = r_sel;
      w_we_next        = r_we;
      w_addr_next      = r_addr;
      w_wdata_next     = r_wdata;
      w_be_next        = r_be;
      w_cnt_next       = r_cnt;
      w_rsp_valid_next = r_rsp_valid;
      w_rsp_err_next   = r_rsp_err;
      w_rsp_rdata_next = r_rsp_rdata;

      case (r_state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (w_req_bad) begin
                  w_state_next     = ST_RESP;
                  w_rsp_valid_next = 1'b1;
                  w_rsp_err_next   = 1'b1;
                  w_rsp_rdata_next = '0;
               end else begin
                  w_state_next = ST_BUSY;
                  w_sel_next   = w_sel_onehot;
                  w_we_next    = bus.req_we;
                  w_addr_next  = bus.req_addr - w_base_sel;
                  w_wdata_next = w_wdata_rep;
                  w_be_next    = w_be;
                  w_cnt_next   = '0;
               end
            end
         end
         ST_BUSY: begin
            if (w_ack) begin
               w_state_next     = ST_RESP;
               w_sel_next       = '0;
               w_we_next        = 1'b0;
               w_be_next        = '0;
               w_rsp_valid_next = 1'b1;
               w_rsp_err_next   = 1'b0;
               w_rsp_rdata_next = r_we ? '0 : w_slv_rdata_sel;
            end else if (r_cnt == 8'(TIMEOUT)) begin
               w_state_next     = ST_RESP;
               w_sel_next       = '0;
               w_we_next        = 1'b0;
               w_be_next        = '0;
               w_rsp_valid_next = 1'b1;
               w_rsp_err_next   = 1'b1;
               w_rsp_rdata_next = '0;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         ST_RESP: begin
            w_state_next     = ST_IDLE;
            w_rsp_valid_next = 1'b0;
            w_rsp_err_next   = 1'b0;
            w_rsp_rdata_next = '0;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------- state register ----------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= ST_IDLE;
         r_sel       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else if (i_clk_en) begin
         r_state     <= w_state_next;
         r_sel       <= w_sel_next;
         r_we        <= w_we_next;
         r_addr      <= w_addr_next;
         r_wdata     <= w_wdata_next;
         r_be        <= w_be_next;
         r_cnt       <= w_cnt_next;
         r_rsp_valid <= w_rsp_valid_next;
         r_rsp_err   <= w_rsp_err_next;
         r_rsp_rdata <= w_rsp_rdata_next;
      end
   end

   assign bus.req_ready = (r_state == ST_IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.slv_sel   = r_sel;
   assign bus.slv_we    = r_we;
   assign bus.slv_addr  = r_addr;
   assign bus.slv_wdata = r_wdata;
   assign bus.slv_be    = r_be;

endmodule
